uart_mmio_tx: RTL
=================

Name: uart_mmio_tx

Overview:
- Memory-mapped UART transmitter attached to the core data bus, in parallel with data_memory_interface.
- It consumes the same bus_address, bus_write_data, bus_read_enable and bus_write_enable signals the core drives.
- It returns read data to the core through its own bus_data_fetched output, which the top level muxes by address window.
- Bytes written by software are buffered in a FIFO and serialised as 8N1 frames at a programmable baud divisor.

Parameters:
- BASE_ADDRESS, 32'hFF200000, base of the 16-byte register window (word aligned).
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, range 2..16.
- DEFAULT_DIVISOR, 16'd434, clocks per bit after reset (50 MHz / 115200).

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_address  in  32  byte address from core.
- bus_write_data  in  32  store data from core.
- bus_format  in  3  funct3 of access; ignored except for decode checks in assertions.
- bus_read_enable  in  1  load strobe.
- bus_write_enable  in  1  store strobe.
- bus_data_fetched  out  32  read data, combinational from registered state; 0 outside window.
- uart_tx  out  1  serial line, idle high.
- tx_irq  out  1  high while FIFO empty and transmitter idle.

Behaviour:
- Hit = bus_address[31:4] == BASE_ADDRESS[31:4]. The offset is bus_address[3:2]; bits [1:0] are ignored.
- Register map:
  - 0x0 TXDATA: a write pushes bus_write_data[7:0]; a read returns 0.
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] count, rest 0. Writing a 1 to bit3 clears overflow; other bits are ignored.
  - 0x8 DIVISOR: r/w, bits[15:0], upper bits read 0.
  - 0xC: reads 0, writes ignored.
- Reset values:
  - uart_tx=1, tx_irq=1, bus_data_fetched=0 when idle bus.
  - FIFO empty, overflow=0, DIVISOR=DEFAULT_DIVISOR, FSM=IDLE.
- Push to a full FIFO: data dropped, overflow set. If a pop happens in the same cycle, the push is accepted and count is unchanged.
- Read is non-destructive, with zero wait states: data is valid in the same cycle the address is presented.
- Effective divisor = max(DIVISOR, 2). The baud counter loads effective divisor-1 at each bit start and counts down to 0.
- A DIVISOR write mid-frame takes effect at the next bit boundary.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop the head into the shift register, go to START.
  - START: uart_tx=0 for one bit time, then DATA.
  - DATA: 8 bits, LSB first, bit index 0..7, then STOP.
  - STOP: uart_tx=1 for one bit time, then IDLE. This allows back-to-back frames with no idle gap beyond the one IDLE cycle.
- Latency: a store to TXDATA in cycle N into an empty FIFO with IDLE FSM gives pop at the end of N+1 and uart_tx low from cycle N+2.
- Frame length = 10 × effective divisor cycles.
- Count wraps never. Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is a separate register of log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: the next cycle has uart_tx=1, FIFO flushed and frame abandoned.
- Simultaneous read and write enable is illegal from the core; if it occurs, the write takes effect and read data reflects pre-write state.

Decomposition:
- Register offsets, STATUS bit positions and the default base address go as `define constants in config.v, next to the existing bus constants.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). It is reusable for a later receiver.

Test Plan:
- Reset, then read 0x4 and 0x8 -> STATUS=32'h0000_0002, DIVISOR=434, uart_tx=1, tx_irq=1.
- Write DIVISOR=4, store 0xA5 to TXDATA at cycle N -> uart_tx low from N+2 for 4 cycles; data bits 1,0,1,0,0,1,0,1 for 4 cycles each; stop high for 4 cycles; busy=1 during the frame; tx_irq=0 until the frame ends.
- DIVISOR=2, 9 back-to-back stores while FIFO idle -> first pops immediately, 8 remain, count=8, full=1; a 10th store gives overflow=1 and that byte is never transmitted; writing 0x8 to STATUS clears overflow.
- DIVISOR=0 -> effective divisor 2; every bit lasts exactly 2 cycles.
- Assert reset mid-DATA with 3 bytes queued -> next cycle uart_tx=1, STATUS=2, no further frames.
- Read an address outside the window (0x1001_0000) and offset 0xC -> bus_data_fetched=0; a store outside the window leaves FIFO count unchanged.

Source files
------------

// File: rtl/uart_mmio_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
// Also used by a future receiver that shares the same register window layout.
package uart_mmio_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'hFF20_0000;

    localparam logic [1:0] OFS_TXDATA  = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_DIVISOR = 2'd2;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_BUSY_BIT     = 2;
    localparam int STATUS_OVERFLOW_BIT = 3;
    localparam int STATUS_COUNT_LSB    = 4;

    localparam logic [15:0] MIN_DIVISOR = 16'd2;

    // Divisors below 2 would leave no room for the load/terminal-count cycle.
    function automatic logic [15:0] effective_divisor(input logic [15:0] divisor);
        return (divisor < MIN_DIVISOR) ? MIN_DIVISOR : divisor;
    endfunction

endpackage

// File: rtl/uart_mmio_tx_sync_fifo.sv
// Synchronous FIFO with separate occupancy counter; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter: register window decode, TX FIFO and
// serialiser FSM with a down-counting baud timer.
//
//   state    | meaning
//   ST_IDLE  | line high; pops FIFO head into shifter when data is waiting
//   ST_START | line low for one bit time
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | line high for one bit time, then back to ST_IDLE
module uart_mmio_tx
    import uart_mmio_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = DEFAULT_BASE_ADDRESS,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [2:0]  bus_format,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_data_fetched,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [1:0]    offset;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_divisor;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    tx_state_t     state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   bit_load;
    logic [15:0]   divisor;
    logic          overflow;
    logic [31:0]   status_word;
    logic          unused_bus_bits;

    assign hit        = (bus_address[31:4] == BASE_ADDRESS[31:4]);
    assign offset     = bus_address[3:2];
    assign wr_txdata  = hit && bus_write_enable && (offset == OFS_TXDATA);
    assign wr_status  = hit && bus_write_enable && (offset == OFS_STATUS);
    assign wr_divisor = hit && bus_write_enable && (offset == OFS_DIVISOR);
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign bit_load   = effective_divisor(divisor) - 16'd1;
    assign tx_irq     = fifo_empty && (state == ST_IDLE);

    assign unused_bus_bits = ^{bus_format, bus_address[1:0], bus_write_data[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wr_txdata),
        .pop     (fifo_pop),
        .wr_data (bus_write_data[7:0]),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            divisor  <= DEFAULT_DIVISOR;
            overflow <= 1'b0;
        end else begin
            if (wr_divisor) begin
                divisor <= bus_write_data[15:0];
            end
            if (wr_txdata && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (wr_status && bus_write_data[STATUS_OVERFLOW_BIT]) begin
                overflow <= 1'b0;
            end
        end
    end

    // The baud timer reloads from the live divisor at every bit start, so a
    // divisor change lands on the next bit boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            uart_tx   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_head;
                        baud_cnt  <= bit_load;
                        uart_tx   <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt  <= bit_load;
                        bit_idx   <= '0;
                        uart_tx   <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= bit_load;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            uart_tx   <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status_word                              = '0;
        status_word[STATUS_FULL_BIT]             = fifo_full;
        status_word[STATUS_EMPTY_BIT]            = fifo_empty;
        status_word[STATUS_BUSY_BIT]             = (state != ST_IDLE);
        status_word[STATUS_OVERFLOW_BIT]         = overflow;
        status_word[STATUS_COUNT_LSB +: CW]      = fifo_count;
    end

    always_comb begin
        bus_data_fetched = '0;
        if (hit && bus_read_enable) begin
            case (offset)
                OFS_STATUS:  bus_data_fetched = status_word;
                OFS_DIVISOR: bus_data_fetched = {16'h0000, divisor};
                default:     bus_data_fetched = '0;
            endcase
        end
    end

endmodule
